shape_draw_scheduler: RTL and testbench

SHAPE_DRAW_SCHEDULER -- requirements
Module: shape_draw_scheduler

---
 rtl/shape_draw_scheduler.sv | 179 +++++++++++++++++
 tb/tb_shape_draw_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shape_draw_scheduler.sv
// Shape draw scheduler: walks the shapes selected by an 8-bit mask, lowest
// index first. For each shape it requests vertex loading, waits for the loader
// to report that drawing is active, and then waits for the line drawer to
// finish. A per-shape watchdog abandons any shape that stalls. All outputs are
// registered.
//
// Handshakes: start_loading is a one-cycle request with no ready. draw_active
// acts as the loader's acknowledge and is only looked at in WAIT_ACK.
// line_done acts as the completion strobe and is only looked at in WAIT_DONE.
// shape_sel stays stable from start_loading until the shape retires.
module shape_draw_scheduler #(
   parameter int TIMEOUT_W      = 20,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start,
   input  logic [7:0] shape_mask,
   input  logic       draw_active,
   input  logic       line_done,
   output logic       start_loading,
   output logic [2:0] shape_sel,
   output logic       busy,
   output logic       frame_done,
   output logic [3:0] shapes_drawn,
   output logic       timeout_err,
   output logic       frame_overrun
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SCAN      = 3'd1,
      ISSUE     = 3'd2,
      WAIT_ACK  = 3'd3,
      WAIT_DONE = 3'd4,
      DONE      = 3'd5
   } state_t;

   // Last watchdog value a shape may spend waiting before it is abandoned.
   localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_t               state;
   state_t               next_state;
   logic [7:0]           pending;
   logic [7:0]           pending_nxt;
   logic [TIMEOUT_W-1:0] watchdog;
   logic [TIMEOUT_W-1:0] watchdog_nxt;
   logic [2:0]           low_idx;
   logic [2:0]           shape_sel_nxt;
   logic                 start_loading_nxt;
   logic                 busy_nxt;
   logic                 frame_done_nxt;
   logic [3:0]           shapes_drawn_nxt;
   logic                 timeout_err_nxt;
   logic                 frame_overrun_nxt;
   logic                 wd_expired;

   // An ack that arrives on the very last watchdog cycle moves the shape into
   // WAIT_DONE with the count already past the limit. Using >= means that shape
   // then retires one cycle later, unless line_done arrives in that cycle.
   assign wd_expired = (watchdog >= WD_LAST);

   // Priority encoder: index of the lowest pending shape, found in one cycle.
   always_comb begin
      low_idx = '0;
      for (int i = 7; i >= 0; i--) begin
         if (pending[i]) begin
            low_idx = i[2:0];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. The exit events (ack, done) beat a watchdog expiry that
   // happens in the same cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (frame_start) next_state = SCAN;
         SCAN:      next_state = (pending == 8'd0) ? DONE : ISSUE;
         ISSUE:     next_state = WAIT_ACK;
         WAIT_ACK: begin
            if (draw_active)     next_state = WAIT_DONE;
            else if (wd_expired) next_state = SCAN;
         end
         WAIT_DONE: begin
            if (line_done)       next_state = SCAN;
            else if (wd_expired) next_state = SCAN;
         end
         DONE:      next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   // Output and datapath next values. The one-cycle strobes are decoded from
   // the next state so that they line up with the state they belong to.
   always_comb begin
      pending_nxt       = pending;
      watchdog_nxt      = watchdog;
      shape_sel_nxt     = shape_sel;
      shapes_drawn_nxt  = shapes_drawn;
      timeout_err_nxt   = timeout_err;
      frame_overrun_nxt = frame_overrun | (frame_start & (state != IDLE));
      start_loading_nxt = (next_state == ISSUE);
      frame_done_nxt    = (next_state == DONE);
      busy_nxt          = (next_state != IDLE);
      case (state)
         IDLE: begin
            if (frame_start) begin
               pending_nxt       = shape_mask;
               shapes_drawn_nxt  = 4'd0;
               timeout_err_nxt   = 1'b0;
               frame_overrun_nxt = 1'b0;
            end
         end
         SCAN: begin
            if (pending != 8'd0) begin
               shape_sel_nxt = low_idx;
               pending_nxt   = pending & (pending - 8'd1);
            end
         end
         ISSUE: begin
            watchdog_nxt = '0;
         end
         WAIT_ACK: begin
            watchdog_nxt = watchdog + 1'b1;
            if (!draw_active && wd_expired) begin
               timeout_err_nxt = 1'b1;
            end
         end
         WAIT_DONE: begin
            watchdog_nxt = watchdog + 1'b1;
            if (line_done) begin
               if (shapes_drawn != 4'd8) begin
                  shapes_drawn_nxt = shapes_drawn + 4'd1;
               end
            end else if (wd_expired) begin
               timeout_err_nxt = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Registered datapath and outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending       <= '0;
         watchdog      <= '0;
         shape_sel     <= '0;
         start_loading <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         shapes_drawn  <= '0;
         timeout_err   <= 1'b0;
         frame_overrun <= 1'b0;
      end else begin
         pending       <= pending_nxt;
         watchdog      <= watchdog_nxt;
         shape_sel     <= shape_sel_nxt;
         start_loading <= start_loading_nxt;
         busy          <= busy_nxt;
         frame_done    <= frame_done_nxt;
         shapes_drawn  <= shapes_drawn_nxt;
         timeout_err   <= timeout_err_nxt;
         frame_overrun <= frame_overrun_nxt;
      end
   end

endmodule

// File: tb/tb_shape_draw_scheduler.sv
// Testbench for shape_draw_scheduler. A behavioural loader/line-drawer
// responder picks, for each issued shape, an ack delay and a done delay. A
// pass-level reference model then predicts the issue order, the timing of
// every strobe, and the end-of-pass counters using plain arithmetic.
module tb_shape_draw_scheduler;

   localparam int TC    = 16;
   localparam int TW    = 8;
   localparam int NEVER = 1000000;
   localparam int INF   = 1 << 30;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_start;
   logic [7:0] shape_mask;
   logic       draw_active;
   logic       line_done;
   logic       start_loading;
   logic [2:0] shape_sel;
   logic       busy;
   logic       frame_done;
   logic [3:0] shapes_drawn;
   logic       timeout_err;
   logic       frame_overrun;

   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   logic [2:0] exp_q[$];
   int         force_a_q[$];
   int         force_d_q[$];

   shape_draw_scheduler #(
      .TIMEOUT_W      (TW),
      .TIMEOUT_CYCLES (TC)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_start   (frame_start),
      .shape_mask    (shape_mask),
      .draw_active   (draw_active),
      .line_done     (line_done),
      .start_loading (start_loading),
      .shape_sel     (shape_sel),
      .busy          (busy),
      .frame_done    (frame_done),
      .shapes_drawn  (shapes_drawn),
      .timeout_err   (timeout_err),
      .frame_overrun (frame_overrun)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         check("idle_done", frame_done, 0);
         check("idle_start", start_loading, 0);
         check("idle_busy", busy, 0);
      end
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_start"}, start_loading, 0);
      check({pfx, "_sel"}, shape_sel, 0);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_done"}, frame_done, 0);
      check({pfx, "_drawn"}, shapes_drawn, 0);
      check({pfx, "_to"}, timeout_err, 0);
      check({pfx, "_ov"}, frame_overrun, 0);
   endtask

   // One draw pass. ov_mode: 0 none, 1 extra frame_start mid-pass, 2 extra
   // frame_start in the frame_done cycle. abort_at > 0 pulls reset at f+abort_at.
   task automatic run_pass(input logic [7:0] mask, input int ov_mode, input int abort_at);
      int f, exp_start, exp_done, n_cnt, cur_exit, rs, ra, rd, e, budget;
      bit any_to, ov_exp, early, noise, resp_on, fin;
      logic [2:0] sel, cur_sel;
      f = cyc;
      frame_start = 1'b1;
      shape_mask  = mask;
      line_done   = 1'b0;
      draw_active = 1'b0;
      n_cnt = 0; any_to = 0; ov_exp = 0; resp_on = 0; fin = 0;
      cur_exit = -1; cur_sel = '0; rs = 0; ra = NEVER; rd = NEVER;
      early = 0; noise = 0;
      budget = 8 * (TC + 4) + 8;
      exp_q.delete();
      for (int i = 0; i < 8; i++) if (mask[i]) exp_q.push_back(3'(i));
      if (exp_q.size() > 0) begin
         exp_start = f + 2;
         exp_done  = INF;
      end else begin
         exp_start = -1;
         exp_done  = f + 2;
      end
      while (!fin) begin
         step();
         frame_start = 1'b0;
         shape_mask  = 8'($urandom);
         line_done   = 1'b0;
         draw_active = 1'b0;
         if (cyc == f + 1) begin
            check("clr_drawn", shapes_drawn, 0);
            check("clr_to", timeout_err, 0);
            check("clr_ov", frame_overrun, 0);
         end
         check("start_loading", start_loading, cyc == exp_start);
         if (cyc == exp_start) begin
            sel = exp_q.pop_front();
            check("shape_sel", shape_sel, sel);
            cur_sel = sel;
            if (force_a_q.size() > 0) begin
               ra = force_a_q.pop_front();
               rd = force_d_q.pop_front();
            end else begin
               ra = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(1, TC - 1);
               case ($urandom_range(0, 9))
                  0:       rd = NEVER;
                  1:       rd = (ra == NEVER) ? 1 : TC - ra;
                  2:       rd = (ra == NEVER) ? 1 : TC - ra + 1;
                  default: rd = (ra == NEVER) ? 1 : $urandom_range(1, TC - ra);
               endcase
            end
            noise = ($urandom_range(0, 1) == 1) && (ra >= 2);
            early = ($urandom_range(0, 3) == 0);
            rs = cyc;
            resp_on = 1;
            // A shape counts only if done arrives within TC waiting cycles.
            if (ra != NEVER && rd != NEVER && ra + rd <= TC) begin
               e = cyc + ra + rd;
               n_cnt++;
            end else begin
               e = cyc + TC;
               any_to = 1;
            end
            cur_exit = e;
            if (exp_q.size() > 0) exp_start = e + 2;
            else begin
               exp_start = -1;
               exp_done  = e + 2;
            end
         end
         if (cyc == cur_exit) check("sel_hold", shape_sel, cur_sel);
         check("frame_done", frame_done, cyc == exp_done);
         check("busy", busy, cyc <= exp_done);
         if (cyc == exp_done + 1) begin
            check("drawn", shapes_drawn, n_cnt);
            check("timeout_err", timeout_err, any_to);
            check("overrun", frame_overrun, ov_exp);
            fin = 1;
         end else if (abort_at > 0 && cyc == f + abort_at) begin
            check("pre_rst_busy", busy, 1);
            #2 rst_n = 1'b0;
            #1 check_all_zero("async_rst");
            for (int k = 0; k < 2; k++) begin
               step();
               check("rst_hold_done", frame_done, 0);
               check("rst_hold_busy", busy, 0);
            end
            rst_n = 1'b1;
            step();
            check("post_rst_done", frame_done, 0);
            check("post_rst_busy", busy, 0);
            fin = 1;
         end else begin
            if (resp_on) begin
               if (ra != NEVER && cyc >= rs + ra)
                  draw_active = early ? (cyc == rs + ra) : (cyc <= rs + ra + rd);
               line_done = (ra != NEVER && rd != NEVER && cyc == rs + ra + rd) ||
                           (noise && cyc == rs + 1);
            end
            if ((ov_mode == 1 && cyc == f + 3) || (ov_mode == 2 && cyc == exp_done)) begin
               frame_start = 1'b1;
               ov_exp = 1;
            end
            if (cyc > f + budget) begin
               check("pass_bound", cyc - f, budget);
               fin = 1;
            end
         end
      end
      frame_start = 1'b0;
      line_done   = 1'b0;
      draw_active = 1'b0;
   endtask

   initial begin
      logic [7:0] m;
      int ov;
      rst_n = 1'b0;
      frame_start = 1'b0;
      shape_mask  = 8'd0;
      draw_active = 1'b0;
      line_done   = 1'b0;
      repeat (3) step();
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // Three shapes, ack after 3, done after 10.
      for (int k = 0; k < 3; k++) begin
         force_a_q.push_back(3);
         force_d_q.push_back(10);
      end
      run_pass(8'b1000_0101, 0, 0);
      idle(2);
      // Empty mask.
      run_pass(8'h00, 0, 0);
      idle(1);
      // Shape 0 never acks, shape 1 completes.
      force_a_q.push_back(NEVER); force_d_q.push_back(1);
      force_a_q.push_back(3);     force_d_q.push_back(5);
      run_pass(8'b0000_0011, 0, 0);
      check("to_sticky", timeout_err, 1);
      idle(2);
      check("to_sticky_idle", timeout_err, 1);
      // Done exactly on the last watchdog cycle, then one cycle too late.
      force_a_q.push_back(4); force_d_q.push_back(TC - 4);
      run_pass(8'h01, 0, 0);
      force_a_q.push_back(4); force_d_q.push_back(TC - 3);
      run_pass(8'h01, 0, 0);
      idle(1);
      // Overruns mid-pass and in the frame_done cycle.
      run_pass(8'h5A, 1, 0);
      run_pass(8'h01, 2, 0);
      idle(1);
      // Reset during WAIT_DONE, then a clean pass.
      force_a_q.push_back(2); force_d_q.push_back(12);
      run_pass(8'h01, 0, 8);
      run_pass(8'h01, 0, 0);
      idle(1);
      // Full mask and randomized passes.
      run_pass(8'hFF, 0, 0);
      for (int p = 0; p < 25; p++) begin
         m  = 8'($urandom);
         ov = (m != 8'd0) ? $urandom_range(0, 2) : 2 * $urandom_range(0, 1);
         run_pass(m, ov, 0);
         idle($urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
